// File: rtl/decode_irq_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_irq_stage
// Brief    : RV32I decode stage with valid/ready handshake, masked interrupts,
//            optional vectored trap entry and bypassed register file reads.
// Revision : 1.0
// ============================================================================
module decode_irq_stage #(
    parameter int unsigned NUM_IRQ  = 4,
    parameter bit          VECTORED = 1'b1,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               i_CLK,
    input  logic               i_RSTn,
    input  logic [NUM_IRQ-1:0] i_IRQ,
    input  logic [NUM_IRQ-1:0] i_IRQ_MASK,
    input  logic               i_IN_VALID,
    input  logic [31:0]        i_INSTRUCTION,
    output logic               o_IN_READY,
    input  logic [31:0]        i_MTVEC,
    input  logic [31:0]        i_MEPC,
    input  logic [31:0]        i_RD,
    input  logic [4:0]         i_RD_PTR,
    input  logic               i_REG_WE,
    output logic               o_OUT_VALID,
    input  logic               i_OUT_READY,
    output logic [2:0]         o_FUNCT3,
    output logic [6:0]         o_FUNCT7,
    output logic [4:0]         o_RD_PTR,
    output logic [31:0]        o_RS1,
    output logic [31:0]        o_RS2,
    output logic [31:0]        o_IMM_VAL,
    output logic [31:0]        o_PC_PIPELINE,
    output logic [31:0]        o_INSTRUCTION,
    output logic               o_REG_WE,
    output logic               o_MEM_WE,
    output logic               o_MEM_RE,
    output logic               o_ECALL,
    output logic               o_IMM,
    output logic               o_JAL,
    output logic               o_LUI,
    output logic               o_AUIPC,
    output logic [31:0]        o_PC,
    output logic [7:0]         o_CORE_STATE,
    output logic               o_TRAP,
    output logic [3:0]         o_TRAP_CAUSE,
    output logic [31:0]        o_TRAP_EPC
);

    typedef enum logic [7:0] {
        ST_USER    = 8'h00,
        ST_MACHINE = 8'h03
    } core_state_t;

    localparam logic [6:0]  c_OP_ALU_R  = 7'b0110011;
    localparam logic [6:0]  c_OP_ALU_I  = 7'b0010011;
    localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  c_OP_STORE  = 7'b0100011;
    localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
    localparam logic [6:0]  c_OP_JALR   = 7'b1100111;
    localparam logic [6:0]  c_OP_LUI    = 7'b0110111;
    localparam logic [6:0]  c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  c_OP_SYSTEM = 7'b1110011;
    localparam logic [31:0] c_NOOP      = 32'h0000_0013;
    localparam logic [11:0] c_MRET_IMM  = 12'h302;

    core_state_t        r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_regs [0:31];

    logic               w_acc;
    logic [NUM_IRQ-1:0] w_irq_act;
    logic               w_pend;
    logic [3:0]         w_cause;
    logic               w_trap;
    logic [31:0]        w_instr;

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic [4:0]         w_rs1_idx;
    logic [4:0]         w_rs2_idx;
    logic [31:0]        w_rs1_val;
    logic [31:0]        w_rs2_val;

    logic [31:0]        w_imm_i;
    logic [31:0]        w_imm_s;
    logic [31:0]        w_imm_b;
    logic [31:0]        w_imm_u;
    logic [31:0]        w_imm_j;
    logic [31:0]        w_imm_sel;

    logic               w_is_alu_r;
    logic               w_is_alu_i;
    logic               w_is_load;
    logic               w_is_store;
    logic               w_is_branch;
    logic               w_is_jal;
    logic               w_is_jalr;
    logic               w_is_lui;
    logic               w_is_auipc;
    logic               w_is_system;
    logic               w_is_mret;
    logic               w_is_shift;

    logic               w_reg_we;
    logic               w_imm_flag;
    logic [2:0]         w_funct3_out;
    logic [6:0]         w_funct7_out;

    logic               w_br_cond;
    logic               w_taken;
    logic [31:0]        w_pc_next;

    assign o_IN_READY   = ~o_OUT_VALID | i_OUT_READY;
    assign w_acc        = i_IN_VALID & o_IN_READY;
    assign o_PC         = r_pc;
    assign o_CORE_STATE = r_state;

    assign w_irq_act = i_IRQ & i_IRQ_MASK;
    assign w_pend    = |w_irq_act;
    assign w_trap    = w_acc & w_pend & (r_state == ST_USER);

    // Scan downward so the lowest active line is the one that sticks.
    always_comb begin
        w_cause = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_irq_act[i]) begin
                w_cause = 4'(i);
            end
        end
    end

    assign w_instr   = w_trap ? c_NOOP : i_INSTRUCTION;
    assign w_opcode  = w_instr[6:0];
    assign w_funct3  = w_instr[14:12];
    assign w_rs1_idx = w_instr[19:15];
    assign w_rs2_idx = w_instr[24:20];

    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                      w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u = {w_instr[31:12], 12'h000};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                      w_instr[20], w_instr[30:21], 1'b0};

    assign w_is_alu_r  = (w_opcode == c_OP_ALU_R);
    assign w_is_alu_i  = (w_opcode == c_OP_ALU_I);
    assign w_is_load   = (w_opcode == c_OP_LOAD);
    assign w_is_store  = (w_opcode == c_OP_STORE);
    assign w_is_branch = (w_opcode == c_OP_BRANCH);
    assign w_is_jal    = (w_opcode == c_OP_JAL);
    assign w_is_jalr   = (w_opcode == c_OP_JALR);
    assign w_is_lui    = (w_opcode == c_OP_LUI);
    assign w_is_auipc  = (w_opcode == c_OP_AUIPC);
    assign w_is_system = (w_opcode == c_OP_SYSTEM);
    assign w_is_mret   = w_is_system & (w_instr[31:20] == c_MRET_IMM);
    assign w_is_shift  = (w_is_alu_r | w_is_alu_i) &
                         ((w_funct3 == 3'd1) | (w_funct3 == 3'd5));

    assign w_reg_we   = w_is_alu_r | w_is_alu_i | w_is_load | w_is_jal |
                        w_is_jalr | w_is_lui | w_is_auipc | w_is_system;
    assign w_imm_flag = w_is_alu_i | w_is_load | w_is_jal | w_is_jalr |
                        w_is_lui | w_is_auipc | w_is_system | w_is_store;

    assign w_funct3_out = (w_is_alu_r | w_is_alu_i | w_is_system) ? w_funct3 : 3'd0;
    assign w_funct7_out = w_is_alu_r ? w_instr[31:25] : 7'd0;

    always_comb begin
        w_imm_sel = w_imm_i;
        if (w_is_lui | w_is_auipc) begin
            w_imm_sel = w_imm_u;
        end else if (w_is_store) begin
            w_imm_sel = w_imm_s;
        end else if (w_is_jal | w_is_jalr) begin
            w_imm_sel = 32'd4;
        end else if (w_is_system) begin
            w_imm_sel = {20'd0, w_instr[31:20]};
        end else if (w_is_shift) begin
            w_imm_sel = {27'd0, w_instr[24:20]};
        end
    end

    // Register file; x0 is never written and its reads are forced to zero.
    always_ff @(posedge i_CLK) begin
        if (i_REG_WE && (i_RD_PTR != 5'd0)) begin
            r_regs[i_RD_PTR] <= i_RD;
        end
    end

    always_comb begin
        w_rs1_val = 32'd0;
        if (w_rs1_idx != 5'd0) begin
            w_rs1_val = (i_REG_WE && (i_RD_PTR == w_rs1_idx)) ? i_RD : r_regs[w_rs1_idx];
        end
    end

    always_comb begin
        w_rs2_val = 32'd0;
        if (w_rs2_idx != 5'd0) begin
            w_rs2_val = (i_REG_WE && (i_RD_PTR == w_rs2_idx)) ? i_RD : r_regs[w_rs2_idx];
        end
    end

    always_comb begin
        case (w_funct3)
            3'd0:    w_br_cond = (w_rs1_val == w_rs2_val);
            3'd1:    w_br_cond = (w_rs1_val != w_rs2_val);
            3'd4:    w_br_cond = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'd5:    w_br_cond = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'd6:    w_br_cond = (w_rs1_val <  w_rs2_val);
            3'd7:    w_br_cond = (w_rs1_val >= w_rs2_val);
            default: w_br_cond = 1'b0;
        endcase
    end

    assign w_taken = w_is_branch & w_br_cond;

    always_comb begin
        w_pc_next = r_pc + 32'd4;
        if (w_trap) begin
            w_pc_next = VECTORED ? (i_MTVEC + {26'd0, w_cause, 2'b00}) : i_MTVEC;
        end else if (w_is_mret && (r_state == ST_MACHINE)) begin
            w_pc_next = i_MEPC;
        end else if (w_is_jal) begin
            w_pc_next = r_pc + w_imm_j;
        end else if (w_is_jalr) begin
            w_pc_next = (w_rs1_val + w_imm_i) & ~32'd1;
        end else if (w_taken) begin
            w_pc_next = r_pc + w_imm_b;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            o_OUT_VALID   <= 1'b0;
            o_FUNCT3      <= 3'd0;
            o_FUNCT7      <= 7'd0;
            o_RD_PTR      <= 5'd0;
            o_RS1         <= 32'd0;
            o_RS2         <= 32'd0;
            o_IMM_VAL     <= 32'd0;
            o_PC_PIPELINE <= 32'd0;
            o_INSTRUCTION <= 32'd0;
            o_REG_WE      <= 1'b0;
            o_MEM_WE      <= 1'b0;
            o_MEM_RE      <= 1'b0;
            o_ECALL       <= 1'b0;
            o_IMM         <= 1'b0;
            o_JAL         <= 1'b0;
            o_LUI         <= 1'b0;
            o_AUIPC       <= 1'b0;
            o_TRAP        <= 1'b0;
            o_TRAP_CAUSE  <= 4'd0;
            o_TRAP_EPC    <= 32'd0;
            r_pc          <= RESET_PC;
            r_state       <= ST_USER;
        end else begin
            o_TRAP <= w_trap;
            if (w_acc) begin
                o_OUT_VALID   <= 1'b1;
                o_FUNCT3      <= w_funct3_out;
                o_FUNCT7      <= w_funct7_out;
                o_RD_PTR      <= w_instr[11:7];
                o_RS1         <= w_rs1_val;
                o_RS2         <= w_rs2_val;
                o_IMM_VAL     <= w_imm_sel;
                o_PC_PIPELINE <= r_pc;
                o_INSTRUCTION <= w_instr;
                o_REG_WE      <= w_reg_we;
                o_MEM_WE      <= w_is_store;
                o_MEM_RE      <= w_is_load;
                o_ECALL       <= w_is_system;
                o_IMM         <= w_imm_flag;
                o_JAL         <= w_is_jal | w_is_jalr;
                o_LUI         <= w_is_lui;
                o_AUIPC       <= w_is_auipc;
                r_pc          <= w_pc_next;
                if (w_trap) begin
                    r_state      <= ST_MACHINE;
                    o_TRAP_CAUSE <= w_cause;
                    o_TRAP_EPC   <= r_pc;
                end else if (w_is_mret && (r_state == ST_MACHINE)) begin
                    r_state <= ST_USER;
                end
            end else if (i_OUT_READY) begin
                o_OUT_VALID <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
